// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN accelerator result path.
//   DEFAULT_*    : default widths for the result stream and the core bus
//   ADDR_SHIFT   : byte address -> 64-bit word index shift
//   packState_t  : packer FSM states (LO = want low half, HI = low half held,
//                  DONE = result set complete)
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_BUS_DATA_WIDTH = 64;
    localparam int DEFAULT_BUS_ADDR_WIDTH = 32;

    // 8 bytes per bus word.
    localparam int ADDR_SHIFT = 3;

    typedef enum logic [1:0] {
        LO   = 2'd0,
        HI   = 2'd1,
        DONE = 2'd2
    } packState_t;

endpackage

// File: rtl/cnn_result_packer_if.sv
// ---------------------------------------------------------------------------
// cnn_result_packer_if
// Groups the result stream (accelerator side) and the read bus (core side).
//   dataIn/validIn/lastIn -> readyOut : result element stream
//   rdEnIn/addrIn -> rdDataOut/rdValidOut : 64-bit read bus, latency 1
// Modports:
//   master : the accelerator/core side driving requests
//   slave  : the packer
// ---------------------------------------------------------------------------
interface cnn_result_packer_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int BUS_ADDR_WIDTH = DEFAULT_BUS_ADDR_WIDTH,
    parameter int BUS_DATA_WIDTH = DEFAULT_BUS_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0]     dataIn;
    logic                      validIn;
    logic                      lastIn;
    logic                      readyOut;

    logic                      rdEnIn;
    logic [BUS_ADDR_WIDTH-1:0] addrIn;
    logic [BUS_DATA_WIDTH-1:0] rdDataOut;
    logic                      rdValidOut;

    modport master (
        output dataIn, validIn, lastIn, rdEnIn, addrIn,
        input  readyOut, rdDataOut, rdValidOut
    );

    modport slave (
        input  dataIn, validIn, lastIn, rdEnIn, addrIn,
        output readyOut, rdDataOut, rdValidOut
    );

endinterface

// File: rtl/sp_ram.sv
// ---------------------------------------------------------------------------
// sp_ram
// Result RAM: one write port and one registered read port (simple dual-port
// arrangement), so reads are never stalled by writes.
//   clkIn, rstIn            : clock, async active-low reset (read register only)
//   wrEnIn/wrAddrIn/wrDataIn: synchronous write
//   rdEnIn/rdAddrIn         : read request, data on rdDataOut next cycle
//   rdDataOut               : holds its value when no read is requested
// ---------------------------------------------------------------------------
module sp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     wrEnIn,
    input  logic [$clog2(DEPTH)-1:0] wrAddrIn,
    input  logic [WIDTH-1:0]         wrDataIn,
    input  logic                     rdEnIn,
    input  logic [$clog2(DEPTH)-1:0] rdAddrIn,
    output logic [WIDTH-1:0]         rdDataOut
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; stale contents
    // are hidden by the owner's write-pointer gating instead.
    always_ff @(posedge clkIn) begin
        if (wrEnIn) begin
            mem[wrAddrIn] <= wrDataIn;
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            rdDataOut <= '0;
        end else if (rdEnIn) begin
            rdDataOut <= mem[rdAddrIn];
        end
    end

endmodule

// File: rtl/cnn_result_packer.sv
// ---------------------------------------------------------------------------
// cnn_result_packer
// Packs pairs of 32-bit result elements into 64-bit words ({hi, lo}) and
// stores them in a local RAM readable by the core.
//   clkIn, rstIn : clock (rising edge), async active-low reset
//   clearIn      : one-cycle pulse restarting collection (beats validIn)
//   bus (slave)  : result stream in, 64-bit read bus out
//   countOut     : number of 64-bit words written
//   doneOut      : last element seen; held until clearIn
// Build option: define CNN_RELU_EN to replace negative elements (sign bit
// set, including -0.0) with zero before packing.
// ---------------------------------------------------------------------------
module cnn_result_packer
    import cnn_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = DEFAULT_BUS_ADDR_WIDTH,
    parameter int BUS_DATA_WIDTH = DEFAULT_BUS_DATA_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RESULT_DEPTH   = 512
) (
    input  logic                           clkIn,
    input  logic                           rstIn,
    input  logic                           clearIn,
    cnn_result_packer_if.slave             bus,
    output logic [$clog2(RESULT_DEPTH):0]  countOut,
    output logic                           doneOut
);

    localparam int IDX_WIDTH = $clog2(RESULT_DEPTH);
    localparam int CNT_WIDTH = IDX_WIDTH + 1;

    packState_t              state, stateNext;
    logic [DATA_WIDTH-1:0]   loR;
    logic [CNT_WIDTH-1:0]    wrPtr;
    logic [DATA_WIDTH-1:0]   elem;
    logic                    ready;
    logic                    accept;
    logic                    loadLo;
    logic                    wrEn;
    logic [BUS_DATA_WIDTH-1:0] wrData;

    logic [IDX_WIDTH-1:0]      rdIdx;
    logic                      rdValidR;
    logic                      rdGateR;
    logic [BUS_DATA_WIDTH-1:0] ramQ;
    logic                      addrUnused;

`ifdef CNN_RELU_EN
    assign elem = bus.dataIn[DATA_WIDTH-1] ? '0 : bus.dataIn;
`else
    assign elem = bus.dataIn;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state <= LO;
            loR   <= '0;
            wrPtr <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples the
            // pre-edge values; blocking = here would create ordering races.
            state <= stateNext;
            if (loadLo) begin
                loR <= elem;
            end
            if (clearIn) begin
                wrPtr <= '0;
            end else if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal
        // unassigned, which would infer a latch.
        stateNext = state;
        ready     = 1'b0;
        loadLo    = 1'b0;
        wrEn      = 1'b0;
        wrData    = {elem, loR};

        unique case (state)
            LO:      ready = (wrPtr < CNT_WIDTH'(RESULT_DEPTH));
            HI:      ready = 1'b1;
            default: ready = 1'b0;
        endcase
        // clearIn wins over a simultaneous element, which is refused.
        if (clearIn) begin
            ready = 1'b0;
        end
        accept = bus.validIn && ready;

        unique case (state)
            LO: begin
                if (accept) begin
                    if (bus.lastIn) begin
                        wrEn      = 1'b1;
                        wrData    = {{DATA_WIDTH{1'b0}}, elem};
                        stateNext = DONE;
                    end else begin
                        loadLo    = 1'b1;
                        stateNext = HI;
                    end
                end
            end
            HI: begin
                if (accept) begin
                    wrEn      = 1'b1;
                    stateNext = bus.lastIn ? DONE : LO;
                end
            end
            DONE:    stateNext = DONE;
            default: stateNext = LO;
        endcase

        if (clearIn) begin
            stateNext = LO;
        end
    end

    assign bus.readyOut = ready;
    assign countOut     = wrPtr;
    assign doneOut      = (state == DONE);

    // ---------------- storage ----------------
    sp_ram #(
        .WIDTH (BUS_DATA_WIDTH),
        .DEPTH (RESULT_DEPTH)
    ) uRam (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .wrEnIn    (wrEn),
        .wrAddrIn  (wrPtr[IDX_WIDTH-1:0]),
        .wrDataIn  (wrData),
        .rdEnIn    (bus.rdEnIn),
        .rdAddrIn  (rdIdx),
        .rdDataOut (ramQ)
    );

    // ---------------- read gating ----------------
    assign rdIdx = bus.addrIn[IDX_WIDTH+ADDR_SHIFT-1:ADDR_SHIFT];
    // Byte-offset and upper address bits do not select a word.
    assign addrUnused = ^{bus.addrIn[BUS_ADDR_WIDTH-1:IDX_WIDTH+ADDR_SHIFT],
                          bus.addrIn[ADDR_SHIFT-1:0]};

    // The gate is evaluated against wrPtr in the request cycle, so a word
    // being written in that same cycle still reads as 0. Both the gate and
    // the RAM output only update on a request, so rdDataOut holds between reads.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            rdValidR <= 1'b0;
            rdGateR  <= 1'b0;
        end else begin
            rdValidR <= bus.rdEnIn;
            if (bus.rdEnIn) begin
                rdGateR <= ({1'b0, rdIdx} < wrPtr);
            end
        end
    end

    assign bus.rdValidOut = rdValidR;
    assign bus.rdDataOut  = rdGateR ? ramQ : '0;

endmodule
